seq_mult: RTL

Parametrised sequential shift-add multiplier with start/done handshake and selectable signed (two's-complement) or unsigned mode. It is the next-generation multiply block: it trades single-cycle array logic for a WIDTH-cycle iterative datapath, so area scales linearly with operand width. It sits behind the top-level I/O wrapper, where operands come from dedicated inputs and the product drives the outputs.

---
 rtl/seq_mult_pkg.sv | 14 +
 rtl/seq_mult_step.sv | 21 ++
 rtl/seq_mult.sv | 94 +++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state encoding, width limits and counter sizing for seq_mult
package seq_mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    // Counter must be able to hold WIDTH itself after the final increment
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// seq_mult_step: one add-shift iteration of the unsigned shift-add multiplier
module seq_mult_step #(
    parameter int WIDTH = 4
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0]   o_mplier
);

    logic [WIDTH:0] w_sum;

    // Conditionally add the multiplicand into the upper half, keeping the carry, then shift right
    always_comb begin
        w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_mplier[0] ? {1'b0, i_mcand} : '0);
        o_acc    = {w_sum, i_acc[WIDTH-1:1]};
        o_mplier = i_mplier >> 1;
    end

endmodule

// File: rtl/seq_mult.sv
// seq_mult: iterative shift-add multiplier with start/done handshake and signed/unsigned modes
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_acc_nx;
    logic [WIDTH-1:0]     w_mplier_nx;

    // Signed operands are reduced to magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits
    always_comb begin
        w_a_mag = (signed_mode && a_in[WIDTH-1]) ? -a_in : a_in;
        w_b_mag = (signed_mode && b_in[WIDTH-1]) ? -b_in : b_in;
    end

    seq_mult_step #(.WIDTH(WIDTH)) u_step (
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_acc_nx),
        .o_mplier (w_mplier_nx)
    );

    // Control FSM and datapath; the product is published one edge after reaching DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_state  <= RUN;
                    r_busy   <= 1'b1;
                    r_mcand  <= w_a_mag;
                    r_mplier <= w_b_mag;
                    r_neg    <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
                RUN: begin
                    r_acc    <= w_acc_nx;
                    r_mplier <= w_mplier_nx;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1))
                        r_state <= DONE;
                end
                DONE: begin
                    r_product <= r_neg ? -r_acc : r_acc;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
